// File: rtl/circle_gen.sv
// Midpoint circle rasteriser: streams outline points or filled-disc spans
// to a VGA pixel port with backpressure and screen clipping.
module circle_gen #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int R_W   = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           fill,
  input  logic [2:0]     colour,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [R_W-1:0] radius,
  input  logic           vga_ready,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);
  localparam int XY_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int C_W  = ((XY_W > R_W) ? XY_W : R_W) + 3;
  localparam int K_W  = R_W + 3;

  typedef enum logic [1:0] {IDLE, INIT, PLOT, DONE} state_t;
  state_t state, state_n;

  logic           fill_r;
  logic [2:0]     col_r;
  logic [X_W-1:0] cx_r;
  logic [Y_W-1:0] cy_r;
  logic [R_W-1:0] rad_r;

  logic signed [K_W-1:0] ox, oy, crit, sx;
  logic [2:0]            idx;
  logic                  gen_busy, out_vld, adv;

  logic signed [K_W-1:0] ox_n, oy_n, crit_n, half, half_nx;
  logic signed [C_W-1:0] cxs, cys, oxw, oyw, sxw, dx, dy, px, py;
  logic                  crit_le0, last_px, in_bnd;

  // A clipped pixel never waits for the sink; a plotted one waits for ready.
  assign adv  = !out_vld || !vga_plot || vga_ready;
  assign done = (state == DONE);

  always_comb begin
    crit_le0 = crit[K_W-1] || (crit == '0);
    oy_n     = oy + K_W'(1);
    ox_n     = crit_le0 ? ox : ox - K_W'(1);
    crit_n   = crit_le0 ? crit + (oy_n <<< 1) + K_W'(1)
                        : crit + ((oy_n - ox_n) <<< 1) + K_W'(1);
    half     = (idx[1:0] >= 2'd2) ? oy : ox;
    half_nx  = (idx[1:0] >= 2'd1) ? oy : ox;
    last_px  = fill_r ? (idx[1:0] == 2'd3 && sx == half) : (idx == 3'd7);
  end

  always_comb begin
    cxs = $signed({{(C_W-X_W){1'b0}}, cx_r});
    cys = $signed({{(C_W-Y_W){1'b0}}, cy_r});
    oxw = C_W'(ox);
    oyw = C_W'(oy);
    sxw = C_W'(sx);
    dx  = idx[0] ? oyw : oxw;
    dy  = idx[0] ? oxw : oyw;
    px  = '0;
    py  = '0;
    if (!fill_r) begin
      px = (idx[2] ^ idx[1]) ? cxs - dx : cxs + dx;
      py = idx[2] ? cys - dy : cys + dy;
    end else begin
      px = cxs + sxw;
      case (idx[1:0])
        2'd0:    py = cys + oyw;
        2'd1:    py = cys - oyw;
        2'd2:    py = cys + oxw;
        default: py = cys - oxw;
      endcase
    end
    in_bnd = !px[C_W-1] && (px < C_W'(SCR_W)) && !py[C_W-1] && (py < C_W'(SCR_H));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = INIT;
      INIT:    state_n = PLOT;
      PLOT:    if (adv && !gen_busy) state_n = DONE;
      DONE:    if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_r     <= 1'b0;
      col_r      <= '0;
      cx_r       <= '0;
      cy_r       <= '0;
      rad_r      <= '0;
      ox         <= '0;
      oy         <= '0;
      crit       <= '0;
      sx         <= '0;
      idx        <= '0;
      gen_busy   <= 1'b0;
      out_vld    <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          fill_r <= fill;
          col_r  <= colour;
          cx_r   <= centre_x;
          cy_r   <= centre_y;
          rad_r  <= radius;
        end
        INIT: begin
          ox       <= K_W'(rad_r);
          oy       <= '0;
          crit     <= K_W'(1) - K_W'(rad_r);
          sx       <= -K_W'(rad_r);
          idx      <= '0;
          gen_busy <= 1'b1;
          out_vld  <= 1'b0;
        end
        PLOT: if (adv) begin
          if (gen_busy) begin
            vga_x      <= px[X_W-1:0];
            vga_y      <= py[Y_W-1:0];
            vga_colour <= col_r;
            vga_plot   <= in_bnd;
            out_vld    <= 1'b1;
            if (last_px) begin
              idx  <= '0;
              oy   <= oy_n;
              ox   <= ox_n;
              crit <= crit_n;
              sx   <= -ox_n;
              if (oy_n > ox_n) gen_busy <= 1'b0;
            end else if (fill_r && sx != half) begin
              sx <= sx + K_W'(1);
            end else begin
              idx <= idx + 3'd1;
              if (fill_r) sx <= -half_nx;
            end
          end else begin
            // Last pixel has just been taken; blank the port for DONE.
            vga_plot <= 1'b0;
            out_vld  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_circle_gen.sv
// Scoreboard bench for circle_gen: expected pixels are queued by the stimulus,
// a negedge monitor pops them as the DUT presents accepted pixels.
module tb_circle_gen;
  logic       clk = 1'b0;
  logic       rst, start, fill, vga_ready, done, vga_plot;
  logic [2:0] colour, vga_colour;
  logic [7:0] centre_x, radius, vga_x;
  logic [6:0] centre_y, vga_y;

  always #5 clk = ~clk;

  circle_gen dut (
    .clk(clk), .rst(rst), .start(start), .fill(fill), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .vga_ready(vga_ready), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b1, rnd_en = 1'b0;

  int hx[16] = '{81,80,79,80,79,80,81,80,81,81,79,79,79,79,81,81};
  int hy[16] = '{60,61,60,61,60,59,60,59,61,61,61,61,59,59,59,59};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic void push(input int x, input int y, input int c);
    pix_t p;
    if (x >= 0 && x < 160 && y >= 0 && y < 120) begin
      p.x = x[7:0];
      p.y = y[6:0];
      p.c = c[2:0];
      exp_q.push_back(p);
    end
  endfunction

  function automatic void model(input int cx, input int cy, input int r, input bit f, input int c);
    int ox, oy, cr;
    ox = r; oy = 0; cr = 1 - r;
    do begin
      if (!f) begin
        push(cx+ox, cy+oy, c); push(cx+oy, cy+ox, c);
        push(cx-ox, cy+oy, c); push(cx-oy, cy+ox, c);
        push(cx-ox, cy-oy, c); push(cx-oy, cy-ox, c);
        push(cx+ox, cy-oy, c); push(cx+oy, cy-ox, c);
      end else begin
        for (int x = cx-ox; x <= cx+ox; x++) push(x, cy+oy, c);
        for (int x = cx-ox; x <= cx+ox; x++) push(x, cy-oy, c);
        for (int x = cx-oy; x <= cx+oy; x++) push(x, cy+ox, c);
        for (int x = cx-oy; x <= cx+oy; x++) push(x, cy-ox, c);
      end
      oy++;
      if (cr <= 0) cr += 2*oy + 1;
      else begin ox--; cr += 2*(oy-ox) + 1; end
    end while (oy <= ox);
  endfunction

  always begin
    @(posedge clk); #1;
    vga_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops on every accepted pixel and checks hold during stalls.
  initial begin
    pix_t        e;
    logic [18:0] prev;
    bit          stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (stall && !rst) begin
        checks++;
        if ({vga_x, vga_y, vga_colour, vga_plot} !== prev) begin
          errors++;
          $display("FAIL stall_hold actual %h required %h", {vga_x, vga_y, vga_colour, vga_plot}, prev);
        end
      end
      stall = vga_plot && !vga_ready && !rst;
      prev  = {vga_x, vga_y, vga_colour, vga_plot};
      if (mon_en && !rst && vga_plot && vga_ready) begin
        checks++;
        if (vga_x >= 8'd160 || vga_y >= 7'd120) begin
          errors++;
          $display("FAIL on_screen actual (%0d,%0d) required x<160 y<120", vga_x, vga_y);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel actual (%0d,%0d) required none", vga_x, vga_y);
        end else begin
          e = exp_q.pop_front();
          if (e != {vga_x, vga_y, vga_colour}) begin
            errors++;
            $display("FAIL pixel actual (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                     vga_x, vga_y, vga_colour, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  task automatic draw(input int cx, input int cy, input int r, input bit f, input int c,
                      output int cyc);
    centre_x = cx[7:0]; centre_y = cy[6:0]; radius = r[7:0];
    fill = f; colour = c[2:0]; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done && cyc < 20000) begin @(posedge clk); #1; cyc++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL draw_timeout actual %0d cycles required done", cyc);
    end
  endtask

  task automatic release_start(input string name);
    start = 1'b0;
    @(posedge clk); #1;
    chk({name, "_done_low"}, done, 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic r1_test(input string name);
    int cyc;
    for (int i = 0; i < 16; i++) push(hx[i], hy[i], 5);
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd1; fill = 1'b0;
    colour = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    // Geometry is already latched; these changes must be ignored.
    centre_x = 8'd0; centre_y = 7'd0; radius = 8'd50; colour = 3'd0; fill = 1'b1;
    chk({name, "_init_plot"}, vga_plot, 0);
    @(posedge clk); #1;
    chk({name, "_lat1_plot"}, vga_plot, 0);
    @(posedge clk); #1;
    chk({name, "_first_plot"}, vga_plot, 1);
    chk({name, "_first_x"}, vga_x, 81);
    cyc = 2;
    while (!done && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    chk({name, "_cycles"}, cyc, 18);
    release_start(name);
  endtask

  initial begin
    int c1, c2;
    rst = 1'b1; start = 1'b0; fill = 1'b0; colour = '0; vga_ready = 1'b1;
    centre_x = '0; centre_y = '0; radius = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_plot", vga_plot, 0);
    chk("rst_done", done, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    r1_test("r1");

    for (int i = 0; i < 8; i++) push(10, 10, 2);
    draw(10, 10, 0, 1'b0, 2, c1);
    chk("r0_outline_cycles", c1, 10);
    release_start("r0_outline");
    for (int i = 0; i < 4; i++) push(10, 10, 4);
    draw(10, 10, 0, 1'b1, 4, c1);
    chk("r0_fill_cycles", c1, 6);
    release_start("r0_fill");

    model(0, 0, 10, 1'b0, 7);
    draw(0, 0, 10, 1'b0, 7, c1);
    release_start("clip");
    model(80, 60, 10, 1'b0, 7);
    draw(80, 60, 10, 1'b0, 7, c2);
    release_start("noclip");
    chk("clip_cycles", c1, c2);
    chk("noclip_cycles", c2, 66);

    model(157, 2, 5, 1'b1, 6);
    draw(157, 2, 5, 1'b1, 6, c1);
    release_start("fill_clip");

    rnd_en = 1'b1;
    model(80, 60, 20, 1'b0, 3);
    draw(80, 60, 20, 1'b0, 3, c1);
    release_start("stall_outline");
    model(80, 60, 20, 1'b1, 1);
    draw(80, 60, 20, 1'b1, 1, c1);
    release_start("stall_fill");
    rnd_en = 1'b0;
    @(posedge clk); #1;

    mon_en = 1'b0;
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd20; fill = 1'b0; colour = 3'd6;
    start = 1'b1;
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_plot", vga_plot, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_plot", vga_plot, 0);
    end
    mon_en = 1'b1;
    r1_test("after_rst");

    for (int i = 0; i < 4; i++) push(10, 10, 3);
    draw(10, 10, 0, 1'b1, 3, c1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_done", done, 1);
      chk("hold_plot", vga_plot, 0);
    end
    release_start("hold");
    for (int i = 0; i < 8; i++) push(10, 10, 1);
    draw(10, 10, 0, 1'b0, 1, c1);
    release_start("redraw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
